// File: rtl/com_tx_pkt.sv
// com_tx_pkt: framed-packet transmitter for the collect-board byte link.
// A frame is SYNC_LEN x 8'hA5, a {btype, bdata} header, an optional
// per-channel parameter payload (DPARAM only) and an XOR checksum. Each byte
// is held for DIV cycles. An error-injection mode corrupts the header or
// checksum on the wire, or drops the checksum byte.
module com_tx_pkt #(
    parameter int NCH      = 4,
    parameter int SYNC_LEN = 2,
    parameter int DIV      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fs,
    output logic               fd,
    output logic               busy,
    input  logic [3:0]         btype,
    input  logic [3:0]         didx,
    input  logic [3:0]         ddidx,
    input  logic [NCH*4-1:0]   freq,
    input  logic [1:0]         err_mode,
    output logic [7:0]         com_txd
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SYNC = 3'd2,
        S_HEAD = 3'd3,
        S_PAY  = 3'd4,
        S_CSUM = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] BT_DIDX   = 4'd5;
    localparam logic [3:0] BT_DPARAM = 4'd6;
    localparam logic [3:0] BT_DDIDX  = 4'd7;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);
    localparam logic [3:0] NCH_LAST  = 4'(NCH - 1);

    // Header data nibble: only the index-carrying types put anything here.
    function automatic logic [3:0] calc_bdata(input logic [3:0] bt,
                                              input logic [3:0] dx,
                                              input logic [3:0] ddx);
        logic [3:0] r;
        case (bt)
            BT_DIDX:  r = dx;
            BT_DDIDX: r = ddx;
            default:  r = 4'h0;
        endcase
        return r;
    endfunction

    // Select channel i from the packed parameter word.
    function automatic logic [3:0] pick_ch(input logic [NCH*4-1:0] f,
                                           input logic [3:0]       i);
        logic [3:0] r;
        r = 4'h0;
        for (int c = 0; c < NCH; c++) begin
            r = (i == 4'(c)) ? f[c*4 +: 4] : r;
        end
        return r;
    endfunction

    // Checksum: XOR of the clean header byte and every payload byte sent.
    function automatic logic [7:0] calc_csum(input logic [7:0]       hdr,
                                             input logic             dparam,
                                             input logic [NCH*4-1:0] f);
        logic [7:0] x;
        x = hdr;
        for (int c = 0; c < NCH; c++) begin
            x = dparam ? (x ^ {4'h0, f[c*4 +: 4]}) : x;
        end
        return x;
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         slot_q, slot_d, slot_nx;
    logic [3:0]         idx_q, idx_d, idx_nx;
    logic [3:0]         btype_q;
    logic [3:0]         bdata_q;
    logic [NCH*4-1:0]   freq_q;
    logic [1:0]         err_q;
    logic [7:0]         txd_q, txd_d;

    logic               last_slot_s;
    logic               is_dparam_s;
    logic [7:0]         hdr_s;
    logic [7:0]         csum_s;
    state_t             after_data_s;

    assign last_slot_s  = (slot_q == DIV_LAST);
    assign is_dparam_s  = (btype_q == BT_DPARAM);
    assign hdr_s        = {btype_q, bdata_q};
    assign csum_s       = calc_csum(hdr_s, is_dparam_s, freq_q);
    // Omitting the checksum byte means the data phase ends straight in DONE.
    assign after_data_s = (err_q == 2'd2) ? S_DONE : S_CSUM;

    // Next-state logic plus byte-slot / byte-index counter stepping.
    always_comb begin
        state_d = state_q;
        slot_nx = slot_q;
        idx_nx  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (fs) state_d = S_LOAD;
                else    state_d = S_IDLE;
            end
            S_LOAD: begin
                state_d = S_SYNC;
            end
            S_SYNC: begin
                if (!last_slot_s) begin
                    slot_nx = slot_q + 8'd1;
                end else if (idx_q == SYNC_LAST) begin
                    state_d = S_HEAD;
                end else begin
                    idx_nx  = idx_q + 4'd1;
                    slot_nx = 8'd0;
                end
            end
            S_HEAD: begin
                if (!last_slot_s)     slot_nx = slot_q + 8'd1;
                else if (is_dparam_s) state_d = S_PAY;
                else                  state_d = after_data_s;
            end
            S_PAY: begin
                if (!last_slot_s) begin
                    slot_nx = slot_q + 8'd1;
                end else if (idx_q == NCH_LAST) begin
                    state_d = after_data_s;
                end else begin
                    idx_nx  = idx_q + 4'd1;
                    slot_nx = 8'd0;
                end
            end
            S_CSUM: begin
                if (!last_slot_s) slot_nx = slot_q + 8'd1;
                else              state_d = S_DONE;
            end
            S_DONE: begin
                if (fs) state_d = S_DONE;
                else    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Both counters restart on every state change.
        slot_d = (state_d != state_q) ? 8'd0 : slot_nx;
        idx_d  = (state_d != state_q) ? 4'd0 : idx_nx;
    end

    // Byte for the upcoming cycle, looked up from the state being entered so
    // the first sync byte appears on the edge that leaves LOAD.
    always_comb begin
        txd_d = 8'h00;
        case (state_d)
            S_SYNC:  txd_d = SYNC_BYTE;
            S_HEAD:  txd_d = hdr_s ^ {(err_q == 2'd3), 7'b000_0000};
            S_PAY:   txd_d = {4'h0, pick_ch(freq_q, idx_d)};
            S_CSUM:  txd_d = csum_s ^ {7'b000_0000, (err_q == 2'd1)};
            default: txd_d = 8'h00;
        endcase
    end

    // State, counters and the registered output byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= 8'd0;
            idx_q   <= 4'd0;
            txd_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

    // Frame parameters are captured once in LOAD and held for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btype_q <= 4'h0;
            bdata_q <= 4'h0;
            freq_q  <= '0;
            err_q   <= 2'd0;
        end else if (state_q == S_LOAD) begin
            btype_q <= btype;
            bdata_q <= calc_bdata(btype, didx, ddidx);
            freq_q  <= freq;
            err_q   <= err_mode;
        end else begin
            btype_q <= btype_q;
            bdata_q <= bdata_q;
            freq_q  <= freq_q;
            err_q   <= err_q;
        end
    end

    assign com_txd = txd_q;
    assign fd      = (state_q == S_DONE);
    assign busy    = (state_q == S_LOAD) || (state_q == S_SYNC) ||
                     (state_q == S_HEAD) || (state_q == S_PAY)  ||
                     (state_q == S_CSUM);

endmodule

// File: tb/tb_com_tx_pkt.sv
// Bench for com_tx_pkt: two instances (DIV = 1 and DIV = 3, NCH = 2,
// SYNC_LEN = 2) driven by directed and random frames, every output cycle
// compared against a frame-level reference model.
module tb_com_tx_pkt;

    localparam int NCH      = 2;
    localparam int SYNC_LEN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs_a, fs_b;
    logic [3:0] btype, didx, ddidx;
    logic [7:0] freq;
    logic [1:0] err_mode;
    logic       fd_a, busy_a, fd_b, busy_b;
    logic [7:0] txd_a, txd_b;

    bit         sel;
    logic [7:0] txd_o;
    logic       fd_o, busy_o;

    logic [7:0] exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    assign txd_o  = sel ? txd_b  : txd_a;
    assign fd_o   = sel ? fd_b   : fd_a;
    assign busy_o = sel ? busy_b : busy_a;

    com_tx_pkt #(.NCH(NCH), .SYNC_LEN(SYNC_LEN), .DIV(1)) dut_a (
        .clk(clk), .rst(rst), .fs(fs_a), .fd(fd_a), .busy(busy_a),
        .btype(btype), .didx(didx), .ddidx(ddidx), .freq(freq),
        .err_mode(err_mode), .com_txd(txd_a)
    );

    com_tx_pkt #(.NCH(NCH), .SYNC_LEN(SYNC_LEN), .DIV(3)) dut_b (
        .clk(clk), .rst(rst), .fs(fs_b), .fd(fd_b), .busy(busy_b),
        .btype(btype), .didx(didx), .ddidx(ddidx), .freq(freq),
        .err_mode(err_mode), .com_txd(txd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic set_fs(input logic v);
        if (sel) fs_b = v;
        else     fs_a = v;
    endtask

    // Reference: the list of bytes a frame should carry on the wire.
    task automatic build_frame(input logic [3:0] bt, input logic [3:0] dx,
                               input logic [3:0] ddx, input logic [7:0] fq,
                               input logic [1:0] em);
        logic [7:0] hdr, cs;
        logic [3:0] bd;
        exp_q.delete();
        for (int s = 0; s < SYNC_LEN; s++) exp_q.push_back(8'hA5);
        bd  = (bt == 4'd5) ? dx : ((bt == 4'd7) ? ddx : 4'h0);
        hdr = {bt, bd};
        exp_q.push_back((em == 2'd3) ? (hdr ^ 8'h80) : hdr);
        cs = hdr;
        if (bt == 4'd6) begin
            for (int c = 0; c < NCH; c++) begin
                exp_q.push_back({4'h0, fq[c*4 +: 4]});
                cs = cs ^ {4'h0, fq[c*4 +: 4]};
            end
        end
        if (em == 2'd1) exp_q.push_back(cs ^ 8'h01);
        else if (em != 2'd2) exp_q.push_back(cs);
    endtask

    // Send one frame from IDLE and check every cycle through the return
    // to IDLE. drop_at: cycle after LOAD at which fs falls (-1 = hold it
    // into DONE for hold_done extra cycles).
    task automatic run_frame(input bit s, input logic [3:0] bt,
                             input logic [3:0] dx, input logic [3:0] ddx,
                             input logic [7:0] fq, input logic [1:0] em,
                             input int drop_at, input int hold_done);
        int d, step;
        logic fs_now;
        sel = s;
        d   = s ? 3 : 1;
        btype = bt; didx = dx; ddidx = ddx; freq = fq; err_mode = em;
        build_frame(bt, dx, ddx, fq, em);
        set_fs(1'b1);
        @(posedge clk); #1;
        step = 0;
        check_eq("load_busy", 32'(busy_o), 32'd1);
        check_eq("load_txd",  32'(txd_o),  32'h00);
        check_eq("load_fd",   32'(fd_o),   32'd0);
        if (drop_at == 0) set_fs(1'b0);
        foreach (exp_q[b]) begin
            for (int k = 0; k < d; k++) begin
                @(posedge clk); #1;
                step++;
                check_eq($sformatf("byte%0d_s%0d", b, k), 32'(txd_o), 32'(exp_q[b]));
                check_eq("frame_busy", 32'(busy_o), 32'd1);
                check_eq("frame_fd",   32'(fd_o),   32'd0);
                if (step == 1) begin
                    btype = 4'($urandom); didx = 4'($urandom); ddidx = 4'($urandom);
                    freq  = 8'($urandom); err_mode = 2'($urandom);
                end
                if (step == drop_at) set_fs(1'b0);
            end
        end
        @(posedge clk); #1;
        check_eq("done_txd",  32'(txd_o),  32'h00);
        check_eq("done_fd",   32'(fd_o),   32'd1);
        check_eq("done_busy", 32'(busy_o), 32'd0);
        fs_now = s ? fs_b : fs_a;
        if (fs_now) begin
            for (int k = 0; k < hold_done; k++) begin
                @(posedge clk); #1;
                check_eq("hold_fd",  32'(fd_o),  32'd1);
                check_eq("hold_txd", 32'(txd_o), 32'h00);
            end
            set_fs(1'b0);
        end
        @(posedge clk); #1;
        check_eq("idle_fd",   32'(fd_o),   32'd0);
        check_eq("idle_busy", 32'(busy_o), 32'd0);
        check_eq("idle_txd",  32'(txd_o),  32'h00);
    endtask

    initial begin
        rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0; sel = 1'b0;
        btype = 4'h0; didx = 4'h0; ddidx = 4'h0; freq = 8'h00; err_mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_txd_a", 32'(txd_a), 32'h00);
        check_eq("rst_fd_a",  32'(fd_a),  32'd0);
        check_eq("rst_busy_a", 32'(busy_a), 32'd0);
        check_eq("rst_txd_b", 32'(txd_b), 32'h00);
        check_eq("rst_fd_b",  32'(fd_b),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ACK, fs held into DONE
        run_frame(1'b0, 4'd1, 4'h0, 4'h0, 8'h00, 2'd0, -1, 3);
        // DIDX / DDIDX / undefined type
        run_frame(1'b0, 4'd5, 4'h5, 4'h0, 8'h00, 2'd0, -1, 0);
        run_frame(1'b0, 4'd7, 4'h0, 4'hA, 8'h00, 2'd0, 2, 0);
        run_frame(1'b0, 4'hF, 4'h3, 4'h9, 8'h00, 2'd0, -1, 1);
        // DPARAM, inputs scrambled after LOAD
        run_frame(1'b0, 4'd6, 4'h0, 4'h0, 8'h73, 2'd0, -1, 0);
        // error injection modes
        run_frame(1'b0, 4'd1, 4'h0, 4'h0, 8'h00, 2'd1, -1, 0);
        run_frame(1'b0, 4'd1, 4'h0, 4'h0, 8'h00, 2'd2, -1, 0);
        run_frame(1'b0, 4'd1, 4'h0, 4'h0, 8'h00, 2'd3, -1, 0);
        run_frame(1'b0, 4'd6, 4'h0, 4'h0, 8'h5C, 2'd2, 1, 0);
        // DIV = 3, NAK, fs dropped during the header
        run_frame(1'b1, 4'd2, 4'h0, 4'h0, 8'h00, 2'd0, 8, 0);

        // Reset during PAY of a DPARAM frame, fs still high
        sel = 1'b0;
        btype = 4'd6; freq = 8'h73; err_mode = 2'd0;
        fs_a = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("pay_ch0", 32'(txd_a), 32'h03);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_txd",  32'(txd_a),  32'h00);
        check_eq("arst_fd",   32'(fd_a),   32'd0);
        check_eq("arst_busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1;
        check_eq("rst_hold_txd", 32'(txd_a), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        run_frame(1'b0, 4'd6, 4'h0, 4'h0, 8'h73, 2'd0, -1, 2);

        // Random frames on both instances
        for (int n = 0; n < 60; n++) begin
            run_frame(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                      8'($urandom), 2'($urandom),
                      int'($urandom_range(0, 14)) - 1, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
